// File: rtl/muldiv_pkg.sv
// Shared encodings for the RV32M multiply/divide sequencer.
// Covers the funct3 op codes, the ALU control codes and the FSM state type.
package muldiv_pkg;

    localparam logic [2:0] MD_MUL  = 3'b000;
    localparam logic [2:0] MD_DIV  = 3'b100;
    localparam logic [2:0] MD_DIVU = 3'b101;
    localparam logic [2:0] MD_REM  = 3'b110;
    localparam logic [2:0] MD_REMU = 3'b111;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;

    typedef enum logic [2:0] {
        IDLE,
        NEGA,
        NEGB,
        ITER,
        FIXUP,
        DONE
    } md_state_t;

endpackage

// File: rtl/muldiv_sequencer.sv
// RV32M mul/div sequencer that borrows the core's shared ALU for shift-add and restoring-divide steps.
// Latency: 33 cycles unsigned, plus 1 each for NEGA/NEGB/FIXUP; fast paths finish in 1 cycle.
// Backpressure: every ALU state holds all registers in any cycle without AluGnt.
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            Start,
    input  logic [2:0]      Op,
    input  logic [XLEN-1:0] OpA,
    input  logic [XLEN-1:0] OpB,
    output logic            Busy,
    output logic            Done,
    output logic [XLEN-1:0] Result,
    output logic            AluReq,
    input  logic            AluGnt,
    output logic [XLEN-1:0] AluSrcA,
    output logic [XLEN-1:0] AluSrcB,
    output logic [3:0]      AluControl,
    input  logic [XLEN-1:0] AluResult
);
    import muldiv_pkg::*;

    md_state_t       state, state_n;
    logic [2:0]      op_q;
    logic [XLEN-1:0] x_q, y_q, acc_q, res_q;
    logic [5:0]      cnt_q;
    logic            sa_q, sb_q;

    logic            reserved, in_div, in_signed, div0, ovf;
    logic [XLEN-1:0] fast_val;
    logic [XLEN:0]   rp;
    logic            ge, is_mul, is_quot, neg_res, last;
    logic [XLEN-1:0] acc_step, x_step, y_step, fin_step, fin_cur;

    // Accept-time decode of the incoming request.
    always_comb begin
        reserved = 1'b1;
        case (Op)
            MD_MUL, MD_DIV, MD_DIVU, MD_REM, MD_REMU: reserved = 1'b0;
            default:                                  reserved = 1'b1;
        endcase
        in_div    = Op[2];
        in_signed = (Op == MD_DIV) || (Op == MD_REM);
        div0      = in_div && (OpB == '0);
        ovf       = in_signed && (OpA == {1'b1, {(XLEN-1){1'b0}}}) && (OpB == '1);
        fast_val  = '0;
        if (reserved)
            fast_val = '0;
        else if (div0)
            fast_val = Op[1] ? OpA : '1;
        else if (ovf)
            fast_val = Op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end

    // x_q holds multiplicand or quotient, y_q multiplier or divisor, acc_q product or remainder.
    always_comb begin
        rp      = {acc_q, x_q[XLEN-1]};
        ge      = rp >= {1'b0, y_q};
        is_mul  = (op_q == MD_MUL);
        is_quot = op_q[2] & ~op_q[1];
        neg_res = ((op_q == MD_DIV) && (sa_q ^ sb_q)) || ((op_q == MD_REM) && sa_q);
        last    = (cnt_q == 6'd31);
        if (is_mul) begin
            acc_step = y_q[0] ? AluResult : acc_q;
            x_step   = x_q << 1;
            y_step   = y_q >> 1;
        end else begin
            acc_step = ge ? AluResult : rp[XLEN-1:0];
            x_step   = {x_q[XLEN-2:0], ge};
            y_step   = y_q;
        end
        fin_step = is_quot ? x_step : acc_step;
        fin_cur  = is_quot ? x_q : acc_q;
    end

    always_comb begin
        state_n    = state;
        AluReq     = 1'b0;
        AluSrcA    = '0;
        AluSrcB    = '0;
        AluControl = ALU_ADD;
        case (state)
            IDLE: begin
                if (Start) begin
                    if (reserved || div0 || ovf)
                        state_n = DONE;
                    else if (in_signed && OpA[XLEN-1])
                        state_n = NEGA;
                    else if (in_signed && OpB[XLEN-1])
                        state_n = NEGB;
                    else
                        state_n = ITER;
                end
            end
            NEGA: begin
                AluReq     = 1'b1;
                AluSrcB    = x_q;
                AluControl = ALU_SUB;
                if (AluGnt)
                    state_n = sb_q ? NEGB : ITER;
            end
            NEGB: begin
                AluReq     = 1'b1;
                AluSrcB    = y_q;
                AluControl = ALU_SUB;
                if (AluGnt)
                    state_n = ITER;
            end
            ITER: begin
                AluReq = 1'b1;
                if (is_mul) begin
                    AluSrcA    = acc_q;
                    AluSrcB    = x_q;
                    AluControl = ALU_ADD;
                end else begin
                    AluSrcA    = rp[XLEN-1:0];
                    AluSrcB    = y_q;
                    AluControl = ALU_SUB;
                end
                if (AluGnt && last)
                    state_n = neg_res ? FIXUP : DONE;
            end
            FIXUP: begin
                AluReq     = 1'b1;
                AluSrcB    = fin_cur;
                AluControl = ALU_SUB;
                if (AluGnt)
                    state_n = DONE;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_n;
    end

    // Result is loaded on the edge into DONE so it is valid during the Done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= '0;
            x_q   <= '0;
            y_q   <= '0;
            acc_q <= '0;
            res_q <= '0;
            cnt_q <= '0;
            sa_q  <= 1'b0;
            sb_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        op_q  <= Op;
                        x_q   <= OpA;
                        y_q   <= OpB;
                        acc_q <= '0;
                        cnt_q <= '0;
                        sa_q  <= in_signed & OpA[XLEN-1];
                        sb_q  <= in_signed & OpB[XLEN-1];
                        if (state_n == DONE)
                            res_q <= fast_val;
                    end
                end
                NEGA: if (AluGnt) x_q <= AluResult;
                NEGB: if (AluGnt) y_q <= AluResult;
                ITER: begin
                    if (AluGnt) begin
                        acc_q <= acc_step;
                        x_q   <= x_step;
                        y_q   <= y_step;
                        cnt_q <= cnt_q + 6'd1;
                        if (last && !neg_res)
                            res_q <= fin_step;
                    end
                end
                FIXUP: if (AluGnt) res_q <= AluResult;
                default: ;
            endcase
        end
    end

    assign Busy   = (state != IDLE);
    assign Done   = (state == DONE);
    assign Result = res_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: vector table with a result/latency scoreboard,
// plus hand-written grant-throttling and mid-operation reset sequences.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        Start;
    logic [2:0]  Op;
    logic [31:0] OpA, OpB;
    logic        Busy, Done;
    logic [31:0] Result;
    logic        AluReq, AluGnt;
    logic [31:0] AluSrcA, AluSrcB;
    logic [3:0]  AluControl;
    logic [31:0] AluResult;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          cyc;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[18];

    always #5 clk = ~clk;

    // Stand-in for the core's shared ALU.
    always_comb begin
        AluResult = (AluControl == 4'b0001) ? (AluSrcA - AluSrcB) : (AluSrcA + AluSrcB);
    end

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Start      (Start),
        .Op         (Op),
        .OpA        (OpA),
        .OpB        (OpB),
        .Busy       (Busy),
        .Done       (Done),
        .Result     (Result),
        .AluReq     (AluReq),
        .AluGnt     (AluGnt),
        .AluSrcA    (AluSrcA),
        .AluSrcB    (AluSrcB),
        .AluControl (AluControl),
        .AluResult  (AluResult)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] res, input int cyc, input bit toggle, input string tag);
        exp_t        e;
        bit          seen;
        bit          was_low;
        int          ctl_bad;
        logic [31:0] pa, pb;
        logic [3:0]  pc;
        @(negedge clk);
        Start  = 1'b1;
        Op     = op;
        OpA    = a;
        OpB    = b;
        AluGnt = 1'b1;
        e.res  = res;
        e.cyc  = cyc;
        sb_q.push_back(e);
        @(posedge clk);
        #1 Start = 1'b0;
        seen    = 1'b0;
        was_low = 1'b0;
        ctl_bad = 0;
        pa = '0; pb = '0; pc = '0;
        for (int n = 1; n <= 200 && !seen; n++) begin
            @(negedge clk);
            if (n == 1)
                check({tag, " busy"}, {31'b0, Busy}, 32'd1);
            if (was_low)
                check({tag, " frozen"}, {AluSrcA ^ pa, AluSrcB[27:0] ^ pb[27:0], AluControl ^ pc}, 32'd0);
            if (op == 3'b000 && AluReq && AluControl !== 4'b0000)
                ctl_bad++;
            if (Done) begin
                seen = 1'b1;
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL %s unexpected_done: got Done with empty scoreboard, required none", tag);
                end else begin
                    e = sb_q.pop_front();
                    check({tag, " result"}, Result, e.res);
                    check({tag, " latency"}, n, e.cyc);
                end
            end else begin
                AluGnt  = toggle ? (n % 2 == 0) : 1'b1;
                was_low = AluReq && !AluGnt;
                pa = AluSrcA;
                pb = AluSrcB;
                pc = AluControl;
            end
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: got no Done in 200 cycles, required Done at cycle %0d", tag, cyc);
            if (sb_q.size() > 0) void'(sb_q.pop_front());
        end
        if (op == 3'b000)
            check({tag, " mul_ctl"}, ctl_bad, 32'd0);
        AluGnt = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int spurious;
        vecs[0]  = '{3'b000, 32'd7,         32'd6,         32'd42,        33};
        vecs[1]  = '{3'b001, 32'd9,         32'd9,         32'd0,         1};
        vecs[2]  = '{3'b101, 32'd100,       32'd7,         32'd14,        33};
        vecs[3]  = '{3'b111, 32'd100,       32'd7,         32'd2,         33};
        vecs[4]  = '{3'b100, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  35};
        vecs[5]  = '{3'b110, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFF,  35};
        vecs[6]  = '{3'b101, 32'd5,         32'd0,         32'hFFFFFFFF,  1};
        vecs[7]  = '{3'b110, 32'd5,         32'd0,         32'd5,         1};
        vecs[8]  = '{3'b100, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  1};
        vecs[9]  = '{3'b110, 32'h80000000,  32'hFFFFFFFF,  32'd0,         1};
        vecs[10] = '{3'b100, 32'hFFFFFF9C,  32'hFFFFFFF9,  32'd14,        35};
        vecs[11] = '{3'b110, 32'd100,       32'hFFFFFFF9,  32'd2,         34};
        vecs[12] = '{3'b100, 32'd100,       32'hFFFFFFF9,  32'hFFFFFFF2,  35};
        vecs[13] = '{3'b000, 32'hFFFFFFFF,  32'd5,         32'hFFFFFFFB,  33};
        vecs[14] = '{3'b101, 32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF,  33};
        vecs[15] = '{3'b100, 32'd5,         32'd0,         32'hFFFFFFFF,  1};
        vecs[16] = '{3'b000, 32'd5,         32'd0,         32'd0,         33};
        vecs[17] = '{3'b011, 32'd1,         32'd1,         32'd0,         1};

        rst_n  = 1'b0;
        Start  = 1'b0;
        Op     = '0;
        OpA    = '0;
        OpB    = '0;
        AluGnt = 1'b1;
        repeat (3) @(negedge clk);
        check("rst busy",   {31'b0, Busy},   32'd0);
        check("rst done",   {31'b0, Done},   32'd0);
        check("rst alureq", {31'b0, AluReq}, 32'd0);
        check("rst result", Result,          32'd0);
        check("rst srca",   AluSrcA,         32'd0);
        check("rst srcb",   AluSrcB,         32'd0);
        check("rst ctl",    {28'b0, AluControl}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++)
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].cyc, 1'b0,
                   $sformatf("vec%0d", i));

        run_op(3'b000, 32'd3, 32'd5, 32'd15, 65, 1'b1, "mul_gnt_toggle");

        // Abort a divide mid-iteration with an asynchronous reset.
        @(negedge clk);
        Start = 1'b1;
        Op    = 3'b101;
        OpA   = 32'd1000;
        OpB   = 32'd3;
        @(posedge clk);
        #1 Start = 1'b0;
        repeat (10) @(negedge clk);
        check("pre_rst alureq", {31'b0, AluReq}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst busy",   {31'b0, Busy},   32'd0);
        check("mid_rst alureq", {31'b0, AluReq}, 32'd0);
        check("mid_rst result", Result,          32'd0);
        check("mid_rst done",   {31'b0, Done},   32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        spurious = 0;
        repeat (40) begin
            @(negedge clk);
            if (Done || Busy) spurious++;
        end
        check("post_rst idle", spurious, 32'd0);

        run_op(3'b101, 32'd9, 32'd3, 32'd3, 33, 1'b0, "divu_after_rst");

        check("scoreboard empty", sb_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
